// File: rtl/rider_gate.sv
// Rider presence gate for a two-sided load-cell platform: debounces rider mount, enables steering after a settle time.
// Latency: ld_cell_diff is combinational; state outputs register on the edge the state changes (IDLE->WAIT->STEER_EN = LIM+2 edges).
// Backpressure: none; inputs are free-running A2D samples consumed every cycle.
//
// Ports:
//   clk, rst           - system clock, asynchronous active-high reset
//   fast_sim           - selects the short settle limit (simulation speed-up)
//   lft_ld, rght_ld    - left/right load-cell samples (unsigned, LD_W bits)
//   ld_cell_diff       - signed lft_ld - rght_ld (LD_W+1 bits, combinational)
//   en_steer           - high while in STEER_EN
//   rider_off          - one-cycle pulse after leaving WAIT/STEER_EN for IDLE
//   gate_state         - state code: IDLE=0, WAIT=1, STEER_EN=2
// Build option: define RIDER_HYST_EN to widen the on/off thresholds by +/-HYST.
module rider_gate #(
    parameter int                 LD_W          = 12,
    parameter logic [LD_W-1:0]    MIN_WT        = 'h200,
    parameter logic [LD_W-1:0]    HYST          = 'h020,
    parameter int                 TMR_W         = 26,
    parameter logic [TMR_W-1:0]   TMR_FULL      = 'h3DFD240,
    parameter logic [TMR_W-1:0]   FAST_TMR_FULL = 'h3FFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fast_sim,
    input  logic [LD_W-1:0]        lft_ld,
    input  logic [LD_W-1:0]        rght_ld,
    output logic signed [LD_W:0]   ld_cell_diff,
    output logic                   en_steer,
    output logic                   rider_off,
    output logic [1:0]             gate_state
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT     = 2'd1;
    localparam logic [1:0] STEER_EN = 2'd2;

    localparam int SW = LD_W + 1;   // sum / abs-diff width
    localparam int CW = LD_W + 5;   // width holding 16*adiff and 15*sum without overflow

`ifdef RIDER_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    // With hysteresis disabled the band collapses to zero and both thresholds sit at MIN_WT.
    localparam logic [SW-1:0] MIN_X  = SW'(MIN_WT);
    localparam logic [SW-1:0] HYST_X = HYST_ON ? SW'(HYST) : '0;
    localparam logic [SW-1:0] ON_TH  = MIN_X + HYST_X;
    localparam logic [SW-1:0] OFF_TH = (MIN_X > HYST_X) ? (MIN_X - HYST_X) : '0;

    logic [1:0]       state, nxt_state;
    logic [TMR_W-1:0] cnt, nxt_cnt, lim;
    logic [SW-1:0]    sum, adiff;
    logic [CW-1:0]    sum_x, adiff_x;
    logic             on, off, tmr_full, diff_gt_1_4, diff_gt_15_16, nxt_off;

    assign ld_cell_diff = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});

    assign sum   = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign adiff = (lft_ld >= rght_ld) ? ({1'b0, lft_ld} - {1'b0, rght_ld})
                                       : ({1'b0, rght_ld} - {1'b0, lft_ld});

    // Ratio tests done by cross-multiplying, so no divide truncation error.
    assign sum_x         = CW'(sum);
    assign adiff_x       = CW'(adiff);
    assign diff_gt_1_4   = (adiff_x << 2) > sum_x;
    assign diff_gt_15_16 = (adiff_x << 4) > ((sum_x << 4) - sum_x);

    assign on  = sum > ON_TH;
    assign off = sum < OFF_TH;

    assign lim      = fast_sim ? FAST_TMR_FULL : TMR_FULL;
    assign tmr_full = cnt >= lim;

    // cnt is only non-zero while settling in WAIT; any other path clears it.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = '0;
        case (state)
            IDLE: begin
                if (on) nxt_state = WAIT;
            end
            WAIT: begin
                if (off)              nxt_state = IDLE;
                else if (diff_gt_1_4) nxt_state = WAIT;
                else if (tmr_full)    nxt_state = STEER_EN;
                else                  nxt_cnt   = (&cnt) ? cnt : cnt + TMR_W'(1);
            end
            STEER_EN: begin
                if (off)                nxt_state = IDLE;
                else if (diff_gt_15_16) nxt_state = WAIT;
            end
            default: nxt_state = IDLE;  // illegal code recovers silently
        endcase
    end

    // Pulse only on a real rider departure, not on illegal-code recovery.
    assign nxt_off = ((state == WAIT) || (state == STEER_EN)) && (nxt_state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            en_steer  <= 1'b0;
            rider_off <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            en_steer  <= (nxt_state == STEER_EN);
            rider_off <= nxt_off;
        end
    end

    assign gate_state = state;

endmodule

// File: tb/tb_rider_gate.sv
// Self-checking bench for rider_gate: directed scenarios plus randomized loads against a reference model.
module tb_rider_gate;

    localparam int     MIN_WT    = 'h200;
    localparam int     HYST      = 'h020;
    localparam longint LIM_FAST  = 'h3FFF;
    localparam longint LIM_SLOW  = 'h3DFD240;
    localparam longint CNT_MAX   = (64'd1 << 26) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               fast_sim;
    logic [11:0]        lft, rght;
    logic signed [12:0] ld_cell_diff;
    logic               en_steer, rider_off;
    logic [1:0]         gate_state;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: 0 = idle, 1 = settling, 2 = steering.
    int     m_st;
    longint m_cnt;
    bit     m_off;

    rider_gate dut (
        .clk          (clk),
        .rst          (rst),
        .fast_sim     (fast_sim),
        .lft_ld       (lft),
        .rght_ld      (rght),
        .ld_cell_diff (ld_cell_diff),
        .en_steer     (en_steer),
        .rider_off    (rider_off),
        .gate_state   (gate_state)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_st  = 0;
        m_cnt = 0;
        m_off = 0;
    endfunction

    function automatic void model_step();
        int     s, ad, on_th, off_th, prev;
        bit     is_on, is_off;
        longint lim;
        s  = int'(lft) + int'(rght);
        ad = (lft > rght) ? int'(lft) - int'(rght) : int'(rght) - int'(lft);
`ifdef RIDER_HYST_EN
        on_th  = MIN_WT + HYST;
        off_th = (MIN_WT > HYST) ? MIN_WT - HYST : 0;
`else
        on_th  = MIN_WT;
        off_th = MIN_WT;
`endif
        is_on  = s > on_th;
        is_off = s < off_th;
        lim    = fast_sim ? LIM_FAST : LIM_SLOW;
        prev   = m_st;
        if (m_st == 0) begin
            if (is_on) m_st = 1;
            m_cnt = 0;
        end else if (m_st == 1) begin
            if (is_off) begin m_st = 0; m_cnt = 0; end
            else if (4 * ad > s) m_cnt = 0;
            else if (m_cnt >= lim) begin m_st = 2; m_cnt = 0; end
            else m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else begin
            if (is_off) m_st = 0;
            else if (16 * ad > 15 * s) m_st = 1;
            m_cnt = 0;
        end
        m_off = (prev != 0) && (m_st == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic drive(input int l, input int r);
        lft  = 12'(l);
        rght = 12'(r);
    endtask

    task automatic test_reset();
        rst = 1'b1; fast_sim = 1'b1; drive(0, 0); model_reset();
        #2;
        n_run++; if (gate_state !== 2'd0) begin n_fail++; $display("FAIL reset_gate_state got %0d want 0", gate_state); end
        n_run++; if (en_steer !== 1'b0) begin n_fail++; $display("FAIL reset_en_steer got %b want 0", en_steer); end
        n_run++; if (rider_off !== 1'b0) begin n_fail++; $display("FAIL reset_rider_off got %b want 0", rider_off); end
        tick();
        #2 rst = 1'b0;
        tick();
        n_run++; if (gate_state !== 2'd0) begin n_fail++; $display("FAIL idle_empty got %0d want 0", gate_state); end
    endtask

    task automatic test_load_math();
        int l, r;
        drive('hFFF, 'hFFF); #1;
        n_run++; if (ld_cell_diff !== 13'sd0) begin n_fail++; $display("FAIL diff_equal got %0d want 0", ld_cell_diff); end
        tick();
        n_run++; if (gate_state !== 2'd1) begin n_fail++; $display("FAIL full_scale_on got %0d want 1", gate_state); end
        drive('hFFF, 0); #1;
        n_run++; if (int'(ld_cell_diff) !== 4095) begin n_fail++; $display("FAIL diff_pos_max got %0d want 4095", ld_cell_diff); end
        drive(0, 'hFFF); #1;
        n_run++; if (int'(ld_cell_diff) !== -4095) begin n_fail++; $display("FAIL diff_neg_max got %0d want -4095", ld_cell_diff); end
        for (int i = 0; i < 8; i++) begin
            l = $urandom_range(0, 'hFFF); r = $urandom_range(0, 'hFFF);
            drive(l, r); #1;
            n_run++; if (int'(ld_cell_diff) !== l - r) begin n_fail++; $display("FAIL diff_rand got %0d want %0d", ld_cell_diff, l - r); end
        end
        // Threshold boundaries around MIN_WT, expectations from the model.
        rst = 1'b1; model_reset(); #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive('h100, 'h100);
                1: drive('h101, 'h100);
                2: drive('h100, 'h100);
                default: drive('h0FF, 'h100);
            endcase
            tick();
            n_run++;
            if (gate_state !== 2'(m_st) || rider_off !== m_off) begin
                n_fail++;
                $display("FAIL threshold_step%0d got state %0d off %b want state %0d off %b", i, gate_state, rider_off, m_st, m_off);
            end
        end
        rst = 1'b1; model_reset(); #2 rst = 1'b0;
    endtask

    task automatic test_latency();
        int n;
        bit ok1;
        fast_sim = 1'b1; drive('h180, 'h180);
        n = 0; ok1 = 1'b0;
        while (n < 20000) begin
            tick(); n++;
            if (n == 1) ok1 = (gate_state === 2'd1);
            if (en_steer === 1'b1) break;
        end
        n_run++; if (!ok1) begin n_fail++; $display("FAIL latency_enter_wait got not-WAIT want 1"); end
        n_run++; if (n !== 16385) begin n_fail++; $display("FAIL latency_edges got %0d want 16385", n); end
        n_run++; if (gate_state !== 2'd2) begin n_fail++; $display("FAIL latency_state got %0d want 2", gate_state); end
    endtask

    task automatic test_steer_to_wait();
        int n;
        drive('h7C0, 'h040); tick();   // 16*adiff == 15*sum exactly: must hold
        n_run++; if (gate_state !== 2'd2 || en_steer !== 1'b1) begin n_fail++; $display("FAIL ratio_15_16_equal got state %0d en %b want 2 1", gate_state, en_steer); end
        drive('h7F0, 'h010); tick();
        n_run++; if (gate_state !== 2'd1 || en_steer !== 1'b0) begin n_fail++; $display("FAIL steer_to_wait got state %0d en %b want 1 0", gate_state, en_steer); end
        drive('h180, 'h180);
        n = 0;
        while (n < 20000) begin
            tick(); n++;
            if (en_steer === 1'b1) break;
        end
        n_run++; if (n !== 16384) begin n_fail++; $display("FAIL resettle_edges got %0d want 16384", n); end
    endtask

    task automatic test_rider_off();
        bit bad;
        drive('h050, 'h050); tick();
        n_run++; if (gate_state !== 2'd0 || en_steer !== 1'b0 || rider_off !== 1'b1) begin
            n_fail++; $display("FAIL steer_exit got state %0d en %b off %b want 0 0 1", gate_state, en_steer, rider_off); end
        bad = 1'b0;
        repeat (5) begin tick(); if (rider_off !== 1'b0 || gate_state !== 2'd0) bad = 1'b1; end
        n_run++; if (bad) begin n_fail++; $display("FAIL off_pulse_width got extra pulse want 0 while idle"); end
    endtask

    task automatic test_wait_toggle();
        bit bad;
        drive('h180, 'h180); tick();
        n_run++; if (gate_state !== 2'd1) begin n_fail++; $display("FAIL toggle_enter got %0d want 1", gate_state); end
        for (int p = 0; p < 34; p++) begin
            if (p % 2 == 0) drive('h300, 'h100); else drive('h180, 'h180);
            bad = 1'b0;
            repeat (1000) begin tick(); if (gate_state !== 2'd1 || en_steer !== 1'b0) bad = 1'b1; end
            n_run++; if (bad) begin n_fail++; $display("FAIL wait_toggle_p%0d left WAIT want 1", p); end
        end
    endtask

    task automatic test_fast_switch();
        bit bad;
        fast_sim = 1'b0;
        drive('h300, 'h100); tick();
        drive('h280, 'h180);               // 4*adiff == sum exactly: keeps counting
        bad = 1'b0;
        repeat (16383) begin tick(); if (gate_state !== 2'd1) bad = 1'b1; end
        n_run++; if (bad) begin n_fail++; $display("FAIL slow_limit_hold left WAIT want 1"); end
        fast_sim = 1'b1; tick();
        n_run++; if (gate_state !== 2'd2 || en_steer !== 1'b1) begin n_fail++; $display("FAIL fast_switch got state %0d en %b want 2 1", gate_state, en_steer); end
    endtask

    task automatic test_random();
        int l, r, len, cat, t, x, errs;
        errs = 0; t = 0;
        while (t < 3000) begin
            len = $urandom_range(1, 40);
            cat = $urandom_range(0, 4);
            case (cat)
                0: begin x = $urandom_range('h110, 'h7FF); l = x; r = x + $urandom_range(0, 8); end
                1: begin l = $urandom_range('h700, 'hFFF); r = $urandom_range(0, 'h20); end
                2: begin l = $urandom_range(0, 'hFF); r = $urandom_range(0, 'hFF); end
                3: begin l = $urandom_range('hF8, 'h108); r = $urandom_range('hF8, 'h108); end
                default: begin l = $urandom_range(0, 'hFFF); r = $urandom_range(0, 'hFFF); end
            endcase
            if ($urandom_range(0, 1) == 1) begin x = l; l = r; r = x; end
            drive(l, r);
            repeat (len) begin
                tick(); t++;
                n_run++;
                if (gate_state !== 2'(m_st) || en_steer !== (m_st == 2) || rider_off !== m_off ||
                    int'(ld_cell_diff) !== l - r) begin
                    n_fail++;
                    if (errs < 10) $display("FAIL random_c%0d got st %0d en %b off %b diff %0d want st %0d off %b diff %0d",
                                            t, gate_state, en_steer, rider_off, ld_cell_diff, m_st, m_off, l - r);
                    errs++;
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drive('h180, 'h180); tick();
        n_run++; if (gate_state === 2'd0) begin n_fail++; $display("FAIL pre_reset_active got 0 want nonzero"); end
        #2 rst = 1'b1; model_reset();
        #1;
        n_run++; if (gate_state !== 2'd0 || en_steer !== 1'b0 || rider_off !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got state %0d en %b off %b want 0 0 0", gate_state, en_steer, rider_off); end
        tick();
        n_run++; if (rider_off !== 1'b0) begin n_fail++; $display("FAIL reset_no_pulse got %b want 0", rider_off); end
        #2 rst = 1'b0;
        tick();
        n_run++; if (gate_state !== 2'd1 || rider_off !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle_eval got state %0d off %b want 1 0", gate_state, rider_off); end
    endtask

    initial begin
        test_reset();
        test_load_math();
        test_latency();
        test_steer_to_wait();
        test_rider_off();
        test_wait_toggle();
        test_fast_switch();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
